// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and digit-count helper for the binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef logic [3:0] bcd_digit_t;
  function automatic int bcd_digits(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    while (v != 0) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_digit.sv
// bin2bcd_digit: double-dabble correction, adds 3 to a BCD digit that is 5 or more.
module bin2bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t i_d,
  output bcd_digit_t o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement (magnitude plus sign flag).
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [3:0]          flags
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t              r_state;
  logic [4*DIGITS-1:0] r_acc;
  logic [WIDTH-1:0]    r_sh;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_flags;
  logic [4*DIGITS-1:0] w_corr;
  logic [DIGITS-1:0]   w_gt9;
  logic [WIDTH-1:0]    w_mag;
  logic                w_sign;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2bcd_digit u_digit (.i_d(r_acc[4*g+:4]), .o_d(w_corr[4*g+:4]));
    assign w_gt9[g] = r_acc[4*g+:4] > 4'd9;
  end
`ifdef BIN2BCD_SIGNED_EN
  logic r_sign;
  // Negating the most negative value wraps to itself, which read unsigned is the right magnitude.
  assign w_mag  = in_bin[WIDTH-1] ? -in_bin : in_bin;
  assign w_sign = r_sign;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sign <= 1'b0;
    else if (r_state == IDLE && in_valid) r_sign <= in_bin[WIDTH-1];
`else
  assign w_mag  = in_bin;
  assign w_sign = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (in_valid) begin
            r_sh    <= w_mag;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_flags <= '0;
            r_state <= SHIFT;
          end
        SHIFT:
          if (r_cnt == '0) begin
            r_flags <= {1'b0, |w_gt9, w_sign, ~|r_acc};
            r_state <= DONE;
          end else begin
            {r_acc, r_sh} <= {w_corr, r_sh} << 1;
            r_cnt         <= r_cnt - 1'b1;
          end
        DONE:    if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign out_bcd   = r_acc;
  assign flags     = r_flags;
endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: binary input width in bits, legal range 4..32.
REQ-002 SHALL have derived constant DIGITS = ceil(WIDTH*log10(2)) BCD digits, which is 5 for WIDTH=16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_bin is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: converter can accept an operand.
REQ-007 SHALL have port in_bin, input, WIDTH bits: binary operand.
REQ-008 SHALL have port out_valid, output, 1 bit: out_bcd and flags are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port out_bcd, output, 4*DIGITS bits: packed BCD result, least significant digit in bits [3:0].
REQ-011 SHALL have port flags, output, 4 bits: {1'b0, overflow, sign, zero}.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept an operand on an edge where in_ready && in_valid: latch in_bin into the shift register, clear the BCD accumulator, load the bit counter with WIDTH, and go to SHIFT.
REQ-015 SHALL, on each SHIFT cycle, first add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one, and decrement the counter.
REQ-016 SHALL go from SHIFT to DONE on the edge where the counter reaches 0, so that out_valid rises exactly WIDTH+1 edges after the accepting edge (17 for WIDTH=16).
REQ-017 SHALL hold out_bcd and flags stable while out_valid=1 && out_ready=0.
REQ-018 SHALL go from DONE to IDLE on an edge where out_ready=1; the next operand is then accepted at the earliest on the following edge.
REQ-019 SHALL ignore in_valid in SHIFT and DONE, with no buffering of operands.
REQ-020 SHALL set flags.zero = 1 when the final magnitude equals 0.
REQ-021 SHALL set flags.overflow = 1 when any out_bcd digit exceeds 9; it SHALL never assert for legal WIDTH and is a verification check only.
REQ-022 SHALL reset all accumulator digits to legal BCD values 0..9 after every SHIFT cycle.

Reset
REQ-023 SHALL, while reset_n=0, immediately force: state IDLE, in_ready 1, out_valid 0, out_bcd 0, flags 0, counter 0.
REQ-024 SHALL, on reset during SHIFT or DONE, discard the conversion in progress with no output produced.
REQ-025 SHALL treat release of reset_n as synchronous to clk and accept an operand on the first edge after release.

Configuration
REQ-026 SHALL use macro BIN2BCD_SIGNED_EN to select signed operation.
REQ-027 SHALL, when BIN2BCD_SIGNED_EN is defined: treat in_bin as two's complement; latch its magnitude at the accepting edge; set flags.sign = in_bin[WIDTH-1]; and convert the most negative value (-2^(WIDTH-1)) correctly, e.g. 16'h8000 -> 32768.
REQ-028 SHALL, when BIN2BCD_SIGNED_EN is not defined: treat in_bin as unsigned, tie flags.sign to 0, and generate no negation logic.

Structure
REQ-029 SHALL place in shared package bcd_pkg: the FSM state enum, the 4-bit bcd_digit_t typedef, and the digit-count function for WIDTH.
REQ-030 SHALL implement the per-digit "add 3 if >= 5" correction in sub-module bin2bcd_digit, instantiated DIGITS times via generate.
REQ-031 SHALL keep datapath registers separate from FSM state, using no latches and no combinational paths from in_valid to out_*.

Verification
REQ-032 SHALL cover: in_bin=0 -> out_bcd=20'h00000, flags=4'b0001, out_valid 17 edges after acceptance.
REQ-033 SHALL cover: in_bin=16'hFFFF -> out_bcd=20'h65535, flags=4'b0000.
REQ-034 SHALL cover: in_bin=1234 with out_ready held 0 for 5 cycles -> out_bcd=20'h01234 held stable throughout, in_ready stays 0, and a second in_valid pulse is ignored.
REQ-035 SHALL cover: back-to-back 9999 then 10000 with out_ready=1 -> results 20'h09999 and 20'h10000, second acceptance one edge after the first DONE exit.
REQ-036 SHALL cover: reset_n pulsed low at SHIFT cycle 8 -> out_valid stays 0, in_ready=1 immediately, and the next operand 42 yields 20'h00042.
REQ-037 SHALL cover, with BIN2BCD_SIGNED_EN: 16'hFFFF -> 20'h00001 with sign=1; 16'h8000 -> 20'h32768 with sign=1.
